// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. The rx line is synchronised, the start bit is
// confirmed at its midpoint, and data and stop bits are sampled one bit-time apart.
module uart_rx #(
  parameter int CLK_FREQ  = 62500000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] uart_data,
  output logic       uart_ready,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  // A bit-time shorter than 4 clocks leaves no room for a midpoint check.
  if (DIV < 4) begin : g_div_check
    $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;
  logic          ferr_q, ferr_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;

  // Two-flop synchroniser; both stages reset to idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic; pulses default low so they last exactly one cycle.
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = ST_START;
      end
      ST_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_M1) begin
          if (rx_s_q) begin
            // Low pulse shorter than half a bit: treat as noise.
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            cnt_d   = '0;
            bit_d   = '0;
          end
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_M1) begin
          sh_d  = {rx_s_q, sh_q[7:1]};
          cnt_d = '0;
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_M1) begin
          cnt_d = '0;
          // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
          if (rx_s_q) begin
            data_d  = sh_q;
            ready_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign uart_data  = data_q;
  assign uart_ready = ready_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
